// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one single-ported memory between the core
// load/store port and the debug/loader port.
// Each access runs IDLE -> ISSUE (strobe) -> optional WAIT (read latency) -> IDLE.
// Round-robin arbitration. core_stall holds the core while its access is pending.
module dmem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    // core load/store port
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    // debug/loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    // memory side
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Port identifiers; also the index of the per-port generate blocks.
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;
    // Wide enough for MEM_LAT-1 up to 3.
    localparam int   CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              owner_reg;
    logic              last_owner_reg;
    logic              we_reg;
    logic              core_rd_out_reg;
    logic              mem_wr_reg, mem_rd_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic              grant_now;
    logic              sample_rd;
    logic              win_next;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Arbitration, next-state and read-sample decision.
    always_comb begin
        state_next = state_reg;
        grant_now  = 1'b0;
        sample_rd  = 1'b0;
        // Debug wins when alone, or on a tie when the core was served last.
        win_next   = dbg_req & (~core_req | (last_owner_reg == OWN_CORE));
        sel_we     = win_next ? dbg_we    : core_we;
        sel_addr   = win_next ? dbg_addr  : core_addr;
        sel_wdata  = win_next ? dbg_wdata : core_wdata;
        case (state_reg)
            IDLE: begin
                if (core_req | dbg_req) begin
                    grant_now  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = IDLE;
                end else if (MEM_LAT == 1) begin
                    // Asynchronous memory: data is already valid in the strobe cycle.
                    sample_rd  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    sample_rd  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latched access, memory strobes, latency counter and ownership tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg       <= OWN_CORE;
            last_owner_reg  <= OWN_DBG;
            we_reg          <= 1'b0;
            mem_wr_reg      <= 1'b0;
            mem_rd_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            cnt_reg         <= '0;
            core_rd_out_reg <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are only raised on a grant.
            mem_wr_reg <= 1'b0;
            mem_rd_reg <= 1'b0;
            if (grant_now) begin
                owner_reg      <= win_next;
                last_owner_reg <= win_next;
                we_reg         <= sel_we;
                mem_addr_reg   <= sel_addr;
                mem_wdata_reg  <= sel_we ? sel_wdata : '0;
                mem_wr_reg     <= sel_we;
                mem_rd_reg     <= ~sel_we;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= CNT_W'(MEM_LAT - 1);
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            // A core load stays outstanding until its data is captured.
            if (grant_now && (win_next == OWN_CORE) && !sel_we) begin
                core_rd_out_reg <= 1'b1;
            end else if (sample_rd) begin
                core_rd_out_reg <= 1'b0;
            end
        end
    end

    // Per-port grant pulse, read-valid pulse and held read data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT_ID = 1'(gi);
        logic              gnt_reg;
        logic              rvalid_reg;
        logic [DATA_W-1:0] rdata_reg;

        // Grant/valid pulses for this port; rdata holds until its next read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gnt_reg    <= 1'b0;
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
            end else begin
                gnt_reg    <= grant_now && (win_next == PORT_ID);
                rvalid_reg <= sample_rd && (owner_reg == PORT_ID);
                if (sample_rd && (owner_reg == PORT_ID)) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end
    end

    assign core_gnt    = g_port[0].gnt_reg;
    assign core_rvalid = g_port[0].rvalid_reg;
    assign core_rdata  = g_port[0].rdata_reg;
    assign dbg_gnt     = g_port[1].gnt_reg;
    assign dbg_rvalid  = g_port[1].rvalid_reg;
    assign dbg_rdata   = g_port[1].rdata_reg;

    assign mem_wr    = mem_wr_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // Core holds while its request is ungranted or its load data is still due.
    assign core_stall = (core_req & ~core_gnt) | (core_rd_out_reg & ~core_rvalid);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with MEM_LAT=1 and one
// with MEM_LAT=3, each with its own small memory model, sharing request inputs.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [8:0]  core_addr, dbg_addr;
    logic [31:0] core_wdata, dbg_wdata;

    logic        core_gnt1, core_rvalid1, core_stall1, dbg_gnt1, dbg_rvalid1, mem_wr1, mem_rd1;
    logic [31:0] core_rdata1, dbg_rdata1, mem_wdata1, mem_rdata1;
    logic [8:0]  mem_addr1;
    logic        core_gnt3, core_rvalid3, core_stall3, dbg_gnt3, dbg_rvalid3, mem_wr3, mem_rd3;
    logic [31:0] core_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
    logic [8:0]  mem_addr3;

    logic [31:0] mem1 [0:511];
    logic [31:0] mem3 [0:511];
    logic        v1, v2;
    logic [8:0]  a1, a2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt1), .core_rvalid(core_rvalid1), .core_rdata(core_rdata1),
        .core_stall(core_stall1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
        .mem_wr(mem_wr1), .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt3), .core_rvalid(core_rvalid3), .core_rdata(core_rdata3),
        .core_stall(core_stall3),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3), .dbg_rdata(dbg_rdata3),
        .mem_wr(mem_wr3), .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    // Memory models: preload during reset, write on strobe. The MEM_LAT=3 model
    // only drives valid data two cycles after the read strobe.
    always @(posedge clk) begin
        if (rst) begin
            mem1[9'h005]  <= 32'h0000_0055;
            mem1[9'h006]  <= 32'h0000_0066;
            mem3[9'h1FF]  <= 32'hCAFE_01FF;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (mem_wr1) mem1[mem_addr1] <= mem_wdata1;
            if (mem_wr3) mem3[mem_addr3] <= mem_wdata3;
            v1 <= mem_rd3;
            v2 <= v1;
        end
        a1 <= mem_addr3;
        a2 <= a1;
    end

    assign mem_rdata1 = mem1[mem_addr1];
    assign mem_rdata3 = v2 ? mem3[a2] : 32'hBADB_AD00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s obs=%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_core_gnt", 32'(core_gnt1), 0);
        check("rst_core_rvalid", 32'(core_rvalid1), 0);
        check("rst_core_rdata", core_rdata1, 0);
        check("rst_dbg_rdata", dbg_rdata3, 0);
        check("rst_mem_wr", 32'(mem_wr1), 0);
        check("rst_mem_rd", 32'(mem_rd3), 0);
        check("rst_mem_addr", 32'(mem_addr1), 0);
        check("rst_mem_wdata", mem_wdata1, 0);
        check("rst_stall_lo", 32'(core_stall1), 0);
        core_req = 1'b1; #1;
        check("rst_stall_eq_req", 32'(core_stall1), 1);
        core_req = 1'b0;
        rst = 1'b0;
        step();

        // Core write 0x1A then read it back (MEM_LAT=1)
        core_req = 1'b1; core_we = 1'b1; core_addr = 9'h01A; core_wdata = 32'hDEAD_BEEF; #1;
        check("wr_stall_req", 32'(core_stall1), 1);
        step();
        check("wr_gnt", 32'(core_gnt1), 1);
        check("wr_dbg_gnt", 32'(dbg_gnt1), 0);
        check("wr_mem_wr", 32'(mem_wr1), 1);
        check("wr_mem_rd", 32'(mem_rd1), 0);
        check("wr_mem_addr", 32'(mem_addr1), 32'h1A);
        check("wr_mem_wdata", mem_wdata1, 32'hDEAD_BEEF);
        core_req = 1'b0;
        step();
        check("wr_gnt_drop", 32'(core_gnt1), 0);
        check("wr_mem_wr_drop", 32'(mem_wr1), 0);
        core_req = 1'b1; core_we = 1'b0; core_wdata = '0; #1;
        check("rd_stall_req", 32'(core_stall1), 1);
        step();
        check("rd_gnt", 32'(core_gnt1), 1);
        check("rd_mem_rd", 32'(mem_rd1), 1);
        check("rd_mem_wdata", mem_wdata1, 0);
        core_req = 1'b0; #1;
        check("rd_stall_outst", 32'(core_stall1), 1);
        step();
        check("rd_rvalid", 32'(core_rvalid1), 1);
        check("rd_rdata", core_rdata1, 32'hDEAD_BEEF);
        check("rd_stall_done", 32'(core_stall1), 0);
        check("rd_dbg_rvalid", 32'(dbg_rvalid1), 0);
        step();
        check("rd_rvalid_pulse", 32'(core_rvalid1), 0);
        check("rd_rdata_hold", core_rdata1, 32'hDEAD_BEEF);

        // Tie after reset: core first, then debug
        pulse_rst();
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h005;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 9'h006;
        step();
        check("tie1_core_gnt", 32'(core_gnt1), 1);
        check("tie1_dbg_gnt", 32'(dbg_gnt1), 0);
        check("tie1_addr", 32'(mem_addr1), 32'h005);
        core_req = 1'b0;
        step();
        check("tie1_core_rvalid", 32'(core_rvalid1), 1);
        check("tie1_core_rdata", core_rdata1, 32'h55);
        check("tie1_dbg_rvalid_a", 32'(dbg_rvalid1), 0);
        step();
        check("tie1_dbg_gnt2", 32'(dbg_gnt1), 1);
        check("tie1_addr2", 32'(mem_addr1), 32'h006);
        check("tie1_core_rvalid_b", 32'(core_rvalid1), 0);
        dbg_req = 1'b0;
        step();
        check("tie1_dbg_rvalid", 32'(dbg_rvalid1), 1);
        check("tie1_dbg_rdata", dbg_rdata1, 32'h66);
        check("tie1_core_rvalid_c", 32'(core_rvalid1), 0);
        check("tie1_core_rdata_hold", core_rdata1, 32'h55);
        step();

        // Core-only write makes core last owner; next tie goes to debug
        core_req = 1'b1; core_we = 1'b1; core_addr = 9'h020; core_wdata = 32'h1234_5678;
        step();
        check("tie2_pre_gnt", 32'(core_gnt1), 1);
        core_req = 1'b0;
        step();
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h020; core_wdata = '0;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 9'h005;
        step();
        check("tie2_dbg_gnt", 32'(dbg_gnt1), 1);
        check("tie2_core_gnt", 32'(core_gnt1), 0);
        check("tie2_addr", 32'(mem_addr1), 32'h005);
        dbg_req = 1'b0; #1;
        check("tie2_core_stall", 32'(core_stall1), 1);
        step();
        check("tie2_dbg_rvalid", 32'(dbg_rvalid1), 1);
        check("tie2_dbg_rdata", dbg_rdata1, 32'h55);
        check("tie2_core_gnt_wait", 32'(core_gnt1), 0);
        step();
        check("tie2_core_gnt2", 32'(core_gnt1), 1);
        check("tie2_addr2", 32'(mem_addr1), 32'h020);
        core_req = 1'b0;
        step();
        check("tie2_core_rvalid", 32'(core_rvalid1), 1);
        check("tie2_core_rdata", core_rdata1, 32'h1234_5678);
        check("tie2_dbg_rvalid_b", 32'(dbg_rvalid1), 0);

        // MEM_LAT=3: debug read 0x1FF, core request arrives during WAIT
        pulse_rst();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
        step();
        check("lat3_dbg_gnt", 32'(dbg_gnt3), 1);
        check("lat3_mem_rd", 32'(mem_rd3), 1);
        check("lat3_addr", 32'(mem_addr3), 32'h1FF);
        dbg_req = 1'b0;
        step();
        check("lat3_mem_rd_w1", 32'(mem_rd3), 0);
        check("lat3_addr_hold", 32'(mem_addr3), 32'h1FF);
        check("lat3_rvalid_w1", 32'(dbg_rvalid3), 0);
        core_req = 1'b1; core_we = 1'b1; core_addr = 9'h030; core_wdata = 32'hA5A5_A5A5; #1;
        check("lat3_core_stall", 32'(core_stall3), 1);
        step();
        check("lat3_core_gnt_w2", 32'(core_gnt3), 0);
        check("lat3_mem_rd_w2", 32'(mem_rd3), 0);
        check("lat3_rvalid_w2", 32'(dbg_rvalid3), 0);
        step();
        check("lat3_dbg_rvalid", 32'(dbg_rvalid3), 1);
        check("lat3_dbg_rdata", dbg_rdata3, 32'hCAFE_01FF);
        check("lat3_core_gnt_rv", 32'(core_gnt3), 0);
        step();
        check("lat3_core_gnt", 32'(core_gnt3), 1);
        check("lat3_core_mem_wr", 32'(mem_wr3), 1);
        check("lat3_core_addr", 32'(mem_addr3), 32'h030);
        check("lat3_dbg_rvalid_pulse", 32'(dbg_rvalid3), 0);
        core_req = 1'b0;
        step();

        // Reset in the WAIT of a core read on the MEM_LAT=3 instance
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h0AB; core_wdata = '0;
        step();
        check("rstw_core_gnt", 32'(core_gnt3), 1);
        check("rstw_mem_rd", 32'(mem_rd3), 1);
        core_req = 1'b0;
        step();
        check("rstw_addr_wait", 32'(mem_addr3), 32'h0AB);
        check("rstw_stall_wait", 32'(core_stall3), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw_addr_async", 32'(mem_addr3), 0);
        check("rstw_stall_async", 32'(core_stall3), 0);
        check("rstw_mem_rd_async", 32'(mem_rd3), 0);
        core_req = 1'b1; #1;
        check("rstw_stall_eq_req", 32'(core_stall3), 1);
        core_req = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rstw_no_rvalid", 32'(core_rvalid3), 0);
        end
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h010; dbg_wdata = 32'h0BAD_F00D;
        step();
        check("rstw_dbg_gnt", 32'(dbg_gnt3), 1);
        check("rstw_dbg_mem_wr", 32'(mem_wr3), 1);
        check("rstw_dbg_addr", 32'(mem_addr3), 32'h010);
        check("rstw_dbg_wdata", mem_wdata3, 32'h0BAD_F00D);
        dbg_req = 1'b0;
        step();
        check("rstw_dbg_gnt_drop", 32'(dbg_gnt3), 0);
        check("rstw_mem_written", mem3[9'h010], 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
